fxp32_sum_sink: RTL and testbench

Result-capture stage directly downstream of the 32-bit pipelined fixed-point CLA adder. It tags each operand pair issued into the adder, captures the adder's sum and overflow flag one cycle later, and saturates overflowed sums to the signed 32-bit limits. Results are buffered in a small FIFO with a valid/ready output, and overflow events are counted. The adder cannot stall, so this block throttles issue with a credit-style `issue_ready`.

---
 rtl/fxp32_pkg.sv | 21 ++
 rtl/fxp32_sat.sv | 27 ++
 rtl/fxp32_sum_sink.sv | 115 +++++++++++
 tb/tb_fxp32_sum_sink.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/fxp32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fxp32_pkg
//  Description : Shared 32-bit fixed-point constants and types used by the
//                CLA adder and its result-capture stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package fxp32_pkg;

  localparam int FXP32_WIDTH = 32;
  localparam logic [FXP32_WIDTH-1:0] FXP32_MAX = 32'h7FFF_FFFF;
  localparam logic [FXP32_WIDTH-1:0] FXP32_MIN = 32'h8000_0000;

  // One buffered result: saturated sum plus the raw adder overflow flag.
  typedef struct packed {
    logic [FXP32_WIDTH-1:0] data;
    logic                   ovf;
  } fxp32_entry_t;

endpackage : fxp32_pkg
`default_nettype wire

// File: rtl/fxp32_sat.sv
`default_nettype none
// ============================================================================
//  Module      : fxp32_sat
//  Description : Combinational signed 32-bit saturation of an adder result.
//                An overflowed sum has the wrong sign bit, so a negative
//                wrapped value clamps to MAX and a positive one to MIN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp32_sat
  import fxp32_pkg::*;
(
  input  logic [FXP32_WIDTH-1:0] sum,
  input  logic                   ovf,
  input  logic                   en,
  output logic [FXP32_WIDTH-1:0] sat_sum
);

  // Clamp toward the limit implied by the (wrapped) sign bit.
  always_comb begin
    sat_sum = sum;
    if (en && ovf) begin
      sat_sum = sum[FXP32_WIDTH-1] ? FXP32_MAX : FXP32_MIN;
    end
  end

endmodule : fxp32_sat
`default_nettype wire

// File: rtl/fxp32_sum_sink.sv
`default_nettype none
// ============================================================================
//  Module      : fxp32_sum_sink
//  Description : Captures results of the non-stallable pipelined adder one
//                cycle after issue, saturates overflowed sums, buffers them
//                in a small FIFO with valid/ready output and counts overflow
//                events. Issue is throttled by a register-only credit check.
//  Revision    : 1.0 - initial release
// ============================================================================
module fxp32_sum_sink
  import fxp32_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter bit SAT_EN = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [FXP32_WIDTH-1:0] sum_in,
  input  logic                   ovf_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [FXP32_WIDTH-1:0] out_data,
  output logic                   out_ovf,
  output logic [CNT_W-1:0]       ovf_count,
  input  logic                   clr_count
);

  localparam int PTR_W = $clog2(DEPTH);
  // One extra bit so occupancy can reach DEPTH and count+pend never wraps.
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

  logic               pend_q,      pend_d;
  logic [PTR_W-1:0]   wr_ptr_q,    wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q,    rd_ptr_d;
  logic [OCC_W-1:0]   count_q,     count_d;
  logic [CNT_W-1:0]   ovf_count_q, ovf_count_d;
  fxp32_entry_t       mem_q [DEPTH];

  fxp32_entry_t       entry_d;
  fxp32_entry_t       head;
  logic [FXP32_WIDTH-1:0] sat_sum;
  logic               wr_en;
  logic               pop;

  fxp32_sat u_sat (
    .sum     (sum_in),
    .ovf     (ovf_in),
    .en      (SAT_EN),
    .sat_sum (sat_sum)
  );

  // Output decode, credit and next-state for pointers/counters.
  always_comb begin
    wr_en        = pend_q;
    out_valid    = (count_q != '0);
    pop          = out_valid & out_ready;
    head         = mem_q[rd_ptr_q];
    out_data     = out_valid ? head.data : '0;
    out_ovf      = out_valid ? head.ovf  : 1'b0;
    // Credit reserves a slot for the result still inside the adder.
    issue_ready  = (count_q + OCC_W'(pend_q)) < DEPTH_OCC;
    ovf_count    = ovf_count_q;

    entry_d.data = sat_sum;
    entry_d.ovf  = ovf_in;

    pend_d       = issue_valid & issue_ready;
    wr_ptr_d     = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

    count_d      = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase

    ovf_count_d  = ovf_count_q;
    if (clr_count) begin
      ovf_count_d = '0;
    end else if (wr_en && ovf_in && (ovf_count_q != '1)) begin
      ovf_count_d = ovf_count_q + CNT_W'(1);
    end
  end

  // Control state; cleared asynchronously so in-flight and buffered results are dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_count_q <= '0;
    end else begin
      pend_q      <= pend_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  // FIFO storage is not reset; occupancy gates everything read from it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= entry_d;
    end
  end

endmodule : fxp32_sum_sink
`default_nettype wire

// File: tb/tb_fxp32_sum_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fxp32_sum_sink
//  Description : Directed self-checking bench. Two instances share stimulus:
//                dut_a (DEPTH=4, SAT_EN=1, CNT_W=16) and
//                dut_b (DEPTH=4, SAT_EN=0, CNT_W=2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fxp32_sum_sink;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [31:0] sum_in;
  logic        ovf_in;
  logic        out_ready;
  logic        clr_count;

  logic        a_issue_ready, a_out_valid, a_out_ovf;
  logic [31:0] a_out_data;
  logic [15:0] a_ovf_count;
  logic        b_issue_ready, b_out_valid, b_out_ovf;
  logic [31:0] b_out_data;
  logic [1:0]  b_ovf_count;

  int errors = 0;
  int checks = 0;

  fxp32_sum_sink #(.DEPTH(4), .SAT_EN(1'b1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(a_issue_ready),
    .sum_in(sum_in), .ovf_in(ovf_in), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .out_ovf(a_out_ovf), .ovf_count(a_ovf_count),
    .clr_count(clr_count)
  );

  fxp32_sum_sink #(.DEPTH(4), .SAT_EN(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(b_issue_ready),
    .sum_in(sum_in), .ovf_in(ovf_in), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .out_ovf(b_out_ovf), .ovf_count(b_ovf_count),
    .clr_count(clr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; sum_in = '0; ovf_in = 1'b0;
    out_ready = 1'b0; clr_count = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_ready_a", 32'(a_issue_ready), 32'd1);
    chk("rst_valid_a", 32'(a_out_valid), 32'd0);
    chk("rst_data_a",  a_out_data, 32'd0);
    chk("rst_ovf_a",   32'(a_out_ovf), 32'd0);
    chk("rst_cnt_a",   32'(a_ovf_count), 32'd0);
    chk("rst_ready_b", 32'(b_issue_ready), 32'd1);
    rst = 1'b0;
    tick();

    // 1: single issue, two-cycle latency
    out_ready = 1'b1; issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0; sum_in = 32'h0000_0005; ovf_in = 1'b0;
    chk("lat_t1_valid", 32'(a_out_valid), 32'd0);
    tick();
    sum_in = '0;
    chk("lat_t2_valid", 32'(a_out_valid), 32'd1);
    chk("lat_t2_data",  a_out_data, 32'h0000_0005);
    chk("lat_t2_ovf",   32'(a_out_ovf), 32'd0);
    tick();
    chk("lat_drained",  32'(a_out_valid), 32'd0);

    // 2: saturation (dut_a) and pass-through (dut_b)
    issue_valid = 1'b1;
    tick();
    sum_in = 32'h8000_0001; ovf_in = 1'b1;
    tick();
    issue_valid = 1'b0; sum_in = 32'h7FFF_FFFE; ovf_in = 1'b1;
    chk("sat_pos_a",   a_out_data, 32'h7FFF_FFFF);
    chk("sat_pos_ovf", 32'(a_out_ovf), 32'd1);
    chk("nosat_b",     b_out_data, 32'h8000_0001);
    chk("nosat_ovf_b", 32'(b_out_ovf), 32'd1);
    tick();
    sum_in = '0; ovf_in = 1'b0;
    chk("sat_neg_a",   a_out_data, 32'h8000_0000);
    chk("nosat2_b",    b_out_data, 32'h7FFF_FFFE);
    chk("ovfcnt_2_a",  32'(a_ovf_count), 32'd2);
    chk("ovfcnt_2_b",  32'(b_ovf_count), 32'd2);
    tick();
    chk("sat_drained", 32'(a_out_valid), 32'd0);

    // 3: fill with out_ready low; exactly 4 issues accepted
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      issue_valid = 1'b1; sum_in = 32'h100 + 32'(k); ovf_in = 1'b0;
      chk($sformatf("credit_%0d", k), 32'(a_issue_ready), (k < 4) ? 32'd1 : 32'd0);
      tick();
    end
    issue_valid = 1'b0; sum_in = '0;
    chk("full_ready", 32'(a_issue_ready), 32'd0);
    chk("full_head",  a_out_data, 32'h101);
    out_ready = 1'b1;
    tick();
    chk("pop1_ready", 32'(a_issue_ready), 32'd1);
    chk("pop1_data",  a_out_data, 32'h102);
    tick();
    chk("pop2_data",  a_out_data, 32'h103);
    tick();
    chk("pop3_data",  a_out_data, 32'h104);
    tick();
    chk("pop_empty",  32'(a_out_valid), 32'd0);
    chk("pop_empty_data", a_out_data, 32'd0);

    // 4: counter saturation at CNT_W=2, then clear beats increment
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk("clr_a", 32'(a_ovf_count), 32'd0);
    chk("clr_b", 32'(b_ovf_count), 32'd0);
    for (int k = 0; k < 8; k++) begin
      issue_valid = (k < 7);
      sum_in      = (k > 0) ? (32'h8000_0000 | 32'(k)) : 32'd0;
      ovf_in      = (k > 0);
      tick();
    end
    issue_valid = 1'b0; sum_in = '0; ovf_in = 1'b0;
    chk("cnt7_a",    32'(a_ovf_count), 32'd7);
    chk("cnt_sat_b", 32'(b_ovf_count), 32'd3);
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0; sum_in = 32'h8000_0000; ovf_in = 1'b1; clr_count = 1'b1;
    tick();
    clr_count = 1'b0; sum_in = '0; ovf_in = 1'b0;
    chk("clr_wins_a", 32'(a_ovf_count), 32'd0);
    chk("clr_wins_b", 32'(b_ovf_count), 32'd0);
    chk("clr_entry_ovf",  32'(a_out_ovf), 32'd1);
    chk("clr_entry_data", a_out_data, 32'h7FFF_FFFF);
    tick();
    chk("clr_drained", 32'(a_out_valid), 32'd0);

    // 5: asynchronous reset with pend=1 and count=2
    out_ready = 1'b0; issue_valid = 1'b1;
    tick();
    sum_in = 32'h0000_000A;
    tick();
    sum_in = 32'h0000_000B;
    tick();
    issue_valid = 1'b0; sum_in = 32'h0000_000C;
    chk("pre_rst_valid", 32'(a_out_valid), 32'd1);
    chk("pre_rst_data",  a_out_data, 32'h0000_000A);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(a_out_valid), 32'd0);
    chk("mid_rst_data",  a_out_data, 32'd0);
    chk("mid_rst_ready", 32'(a_issue_ready), 32'd1);
    chk("mid_rst_valid_b", 32'(b_out_valid), 32'd0);
    tick();
    rst = 1'b0; sum_in = 32'h0000_000D;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("post_rst_valid_%0d", k), 32'(a_out_valid), 32'd0);
    end
    chk("post_rst_ready", 32'(a_issue_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fxp32_sum_sink
`default_nettype wire
